// File: rtl/serial_tx_pkg.sv
// Shared state encoding and line levels for the serial_tx transmitter.
// Macro SERIAL_TX_PARITY_EN adds the PARITY state.
package serial_tx_pkg;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   localparam int unsigned PERIOD_W = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period counter: counts 0..period-1, bit_end is high during the last
// cycle of every bit. restart realigns the count to a new frame.
module bit_timer
   import serial_tx_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                restart,
   input  logic                run,
   input  logic [PERIOD_W-1:0] period,
   output logic                bit_end
);

   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W-1:0] cnt_next_c;
   logic                wrap_c;

   assign wrap_c = (cnt == period - PERIOD_W'(1));

   always_comb begin
      cnt_next_c = '0;
      if (run && !restart && !wrap_c) begin
         cnt_next_c = cnt + PERIOD_W'(1);
      end
   end

   // bit_end is precomputed from the next count so it stays registered
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         bit_end <= 1'b0;
      end else begin
         cnt     <= cnt_next_c;
         bit_end <= (run || restart) && (cnt_next_c == period - PERIOD_W'(1));
      end
   end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W bits LSB first, optional even parity
// (SERIAL_TX_PARITY_EN), one stop bit; each bit held CLKS_PER_BIT cycles.
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int unsigned       IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   state_t            state;
   logic [DATA_W-1:0] shift;
   logic [IDX_W-1:0]  bit_idx;
   logic              bit_end;
   logic              accept_c;
`ifdef SERIAL_TX_PARITY_EN
   logic              par;
`endif

   assign accept_c = in_valid && in_ready;

   bit_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (accept_c),
      .run     (busy),
      .period  (PERIOD_W'(CLKS_PER_BIT)),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tx       <= IDLE_LEVEL;
         in_ready <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         shift    <= '0;
         bit_idx  <= '0;
`ifdef SERIAL_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= START;
                  tx       <= START_LEVEL;
                  busy     <= 1'b1;
                  in_ready <= 1'b0;
                  shift    <= in_data;
                  bit_idx  <= '0;
`ifdef SERIAL_TX_PARITY_EN
                  par      <= ^in_data;
`endif
               end
            end
            START: begin
               if (bit_end) begin
                  state <= DATA;
                  tx    <= shift[0];
                  shift <= shift >> 1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == LAST_IDX) begin
                     bit_idx <= '0;
`ifdef SERIAL_TX_PARITY_EN
                     state   <= PARITY;
                     tx      <= par;
`else
                     state   <= STOP;
                     tx      <= STOP_LEVEL;
`endif
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                     tx      <= shift[0];
                     shift   <= shift >> 1;
                  end
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state <= STOP;
                  tx    <= STOP_LEVEL;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  state    <= IDLE;
                  tx       <= IDLE_LEVEL;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
                  done     <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               tx       <= IDLE_LEVEL;
               busy     <= 1'b0;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: a driver queues expected frames, a monitor
// checks every line cycle against a slot-based frame model.
module tb_serial_tx;

   localparam int DW = 8;
`ifdef SERIAL_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   typedef struct {
      logic [7:0] word;
      int         cpb;
      bit         b2b;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          sel = 1'b0;
   logic          in_valid4, in_valid1;
   logic          in_ready4, tx4, busy4, done4;
   logic          in_ready1, tx1, busy1, done1;
   logic          in_ready_m, tx_m, busy_m, done_m;

   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;
   int   last_done_cyc = -10;
   bit   in_frame = 1'b0;
   exp_t exp_q[$];

   assign in_valid4  = in_valid & ~sel;
   assign in_valid1  = in_valid & sel;
   assign in_ready_m = sel ? in_ready1 : in_ready4;
   assign tx_m       = sel ? tx1 : tx4;
   assign busy_m     = sel ? busy1 : busy4;
   assign done_m     = sel ? done1 : done4;

   serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid4),
      .in_ready(in_ready4), .tx(tx4), .busy(busy4), .done(done4)
   );

   serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid1),
      .in_ready(in_ready1), .tx(tx1), .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input bit ok, input int act, input int exp);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Line level in bit slot 'slot' of a frame: start, data LSB first, parity, stop
   function automatic logic frame_level(input logic [7:0] w, input int slot);
      logic [7:0] v;
      v = w;
      if (slot == 0) return 1'b0;
      if (slot <= DW) return v[slot-1];
      if (PAR != 0 && slot == DW + 1) return ^v;
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (!in_ready_m && t < 500) begin
         step();
         t++;
      end
      chk("wait_ready", in_ready_m, in_ready_m, 1);
   endtask

   task automatic send(input logic [7:0] w);
      wait_ready();
      in_valid = 1'b1;
      in_data  = w;
      exp_q.push_back('{word: w, cpb: (sel ? 1 : 4), b2b: 1'b0});
      step();
      in_valid = 1'b0;
      in_data  = DW'($urandom);
   endtask

   // Monitor: follows each frame from its first busy cycle through done
   exp_t e;
   int   n, tx_bad, busy_bad;
   logic tx_act, exp_lvl;
   bit   aborted;
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (busy_m && !reset) begin
            in_frame = 1'b1;
            chk("frame_expected", exp_q.size() != 0, 1, 0);
            if (exp_q.size() == 0) begin
               for (int k = 0; k < 500 && busy_m; k++) @(negedge clk);
            end else begin
               e = exp_q.pop_front();
               n = (2 + DW + PAR) * e.cpb;
               tx_bad = -1; tx_act = 1'b0; exp_lvl = 1'b0;
               busy_bad = 0; aborted = 1'b0;
               if (e.b2b) chk("no_gap", cyc == last_done_cyc + 1, cyc, last_done_cyc + 1);
               for (int c = 0; c < n; c++) begin
                  if (c > 0) @(negedge clk);
                  if (tx_m !== frame_level(e.word, c / e.cpb) && tx_bad < 0) begin
                     tx_bad  = c;
                     tx_act  = tx_m;
                     exp_lvl = frame_level(e.word, c / e.cpb);
                  end
                  if (busy_m !== 1'b1 || done_m !== 1'b0 || in_ready_m !== 1'b0) busy_bad++;
                  if (reset) begin
                     aborted = 1'b1;
                     break;
                  end
               end
               chk($sformatf("frame_tx w=%0h cycle %0d", e.word, tx_bad), tx_bad < 0,
                   int'(tx_act), int'(exp_lvl));
               chk($sformatf("frame_busy w=%0h", e.word), busy_bad == 0, busy_bad, 0);
               @(negedge clk);
               if (aborted) begin
                  chk("reset_abort {tx,busy,rdy,done}", {tx_m, busy_m, in_ready_m, done_m} == 4'b1010,
                      int'({tx_m, busy_m, in_ready_m, done_m}), 4'b1010);
                  @(negedge clk);
                  chk("no_done_after_reset", done_m == 1'b0, done_m, 0);
               end else begin
                  chk($sformatf("done_cycle w=%0h {tx,busy,rdy,done}", e.word),
                      {tx_m, busy_m, in_ready_m, done_m} == 4'b1011,
                      int'({tx_m, busy_m, in_ready_m, done_m}), 4'b1011);
                  last_done_cyc = cyc;
               end
            end
            in_frame = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      checks++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin : driver
      int t;
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("reset_state4", {tx4, busy4, in_ready4, done4} == 4'b1010,
          int'({tx4, busy4, in_ready4, done4}), 4'b1010);
      chk("reset_state1", {tx1, busy1, in_ready1, done1} == 4'b1010,
          int'({tx1, busy1, in_ready1, done1}), 4'b1010);

      // Directed words (parity 0 and 1)
      send(8'hA5);
      send(8'h07);

      // Back-to-back with in_valid held high
      wait_ready();
      in_valid = 1'b1;
      in_data  = 8'h3C;
      exp_q.push_back('{word: 8'h3C, cpb: 4, b2b: 1'b0});
      step();
      in_data = 8'hC3;
      exp_q.push_back('{word: 8'hC3, cpb: 4, b2b: 1'b1});
      t = 0;
      while (!in_ready_m && t < 500) begin
         step();
         t++;
      end
      step();
      in_valid = 1'b0;

      // Reset during data bit 3, with a competing in_valid
      send(8'h96);
      repeat (17) step();
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
      repeat (4) step();

      // Word offered mid-frame must be ignored
      send(8'h5A);
      repeat (10) step();
      in_valid = 1'b1;
      in_data  = 8'hFF;
      step();
      in_valid = 1'b0;

      for (int i = 0; i < 8; i++) begin
         send(8'($urandom));
         repeat ($urandom_range(0, 3)) step();
      end

      // One clock per bit
      wait_ready();
      repeat (2) step();
      sel = 1'b1;
      step();
      send(8'h01);
      for (int i = 0; i < 3; i++) send(8'($urandom));

      t = 0;
      while ((exp_q.size() != 0 || in_frame) && t < 2000) begin
         step();
         t++;
      end
      repeat (5) step();
      chk("queue_drained", exp_q.size() == 0 && !in_frame, exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload bits per frame; legal range 1..32.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4: clk cycles each line bit is held; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled only on rising clk.
REQ-005 SHALL have port in_data  input  DATA_W  parallel word to transmit.
REQ-006 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  high exactly while the transmitter is in IDLE.
REQ-008 SHALL have port tx  output  1  registered serial line output, idle high.
REQ-009 SHALL have port busy  output  1  high from the cycle after acceptance until the last stop-bit cycle, inclusive.
REQ-010 SHALL have port done  output  1  one-cycle pulse after each completed frame.

Function
REQ-011 SHALL accept a word on any rising edge where in_valid and in_ready are both high, capturing in_data into an internal shift register.
REQ-012 SHALL ignore in_valid while in_ready is low; in_data changes during a frame SHALL NOT affect the frame.
REQ-013 SHALL implement states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
REQ-014 SHALL drive tx low for the START bit beginning the cycle after acceptance (1-cycle latency).
REQ-015 SHALL send DATA_W data bits LSB first, each for exactly CLKS_PER_BIT cycles.
REQ-016 SHALL drive one stop bit (tx high) for CLKS_PER_BIT cycles.
REQ-017 SHALL occupy exactly (2 + DATA_W + P) * CLKS_PER_BIT cycles with busy high, where P is 1 with parity and 0 without.
REQ-018 SHALL return to IDLE and pulse done in the cycle after the final stop-bit cycle, with in_ready high in the same cycle.
REQ-019 SHALL allow back-to-back frames: a word accepted in the done cycle starts its START bit the next cycle, with no extra idle bit.
REQ-020 SHALL use a bit-period counter that counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary; with CLKS_PER_BIT=1, one bit per cycle.
REQ-021 SHALL use a data-bit index that wraps without overflow for DATA_W up to 32.

Reset
REQ-022 SHALL, on reset, enter IDLE with tx=1, in_ready=1, busy=0, done=0, and counters and shift register cleared.
REQ-023 SHALL abort a frame in progress on reset, with tx=1 in the cycle following the reset edge and no done pulse.
REQ-024 SHALL give reset priority over a simultaneous in_valid; the word is not accepted.

Configuration
REQ-025 SHALL, when macro SERIAL_TX_PARITY_EN is defined, insert one even-parity bit (XOR of all data bits) between DATA and STOP, held for CLKS_PER_BIT cycles.
REQ-026 SHALL, when SERIAL_TX_PARITY_EN is undefined, omit the PARITY state and all its logic, transitioning DATA -> STOP.

Structure
REQ-027 SHALL place the state encoding and the line-level constants (IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1) in a shared package, serial_tx_pkg.
REQ-028 SHALL implement the bit-period counter as one sub-module, bit_timer, with a period input and a one-cycle bit_end output.

Verification
REQ-029 SHALL test: DATA_W=8, CLKS_PER_BIT=4, no parity, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles; 40 busy cycles; done in cycle 41.
REQ-030 SHALL test: same setup with SERIAL_TX_PARITY_EN, send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1; 44 busy cycles.
REQ-031 SHALL test: in_valid held high with 0x3C then 0xC3 -> second START bit begins the cycle after done; no idle gap.
REQ-032 SHALL test: assert reset during data bit 3 -> next cycle tx=1, busy=0, in_ready=1, and no done pulse.
REQ-033 SHALL test: pulse in_valid with 0xFF mid-frame -> the word is ignored and the current frame is unchanged.
REQ-034 SHALL test: CLKS_PER_BIT=1, send 0x01 -> frame 0,1,0,0,0,0,0,0,0,1 over 10 cycles.
